// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Single-issue ALU execution unit with a valid/ready handshake on both sides.
// Single-cycle operations (AND, XOR, SLL, ADD, SUB, SRA, illegal) complete one
// cycle after the transfer. MUL is a 32-step shift-add multiplier that
// produces the low 32 bits of the product 32 cycles after the transfer.
// A result is held in DONE until downstream takes it.
//
// Ports
//   clk_i      : clock, rising-edge active
//   rst_i      : asynchronous active-low reset
//   valid_i    : upstream offers an operation
//   ready_o    : unit can accept an operation (high only in IDLE)
//   ALUCtrl_i  : 3-bit opcode
//   data1_i    : operand rs1
//   data2_i    : operand rs2 / immediate
//   valid_o    : data_o/zero_o hold a completed result (high only in DONE)
//   ready_i    : downstream consumes the result
//   data_o     : registered result
//   zero_o     : registered flag, high when data_o == 0
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              zero_o
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MUL_RUN = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]        state_reg;
  logic [DATA_W-1:0] mcand_reg;
  logic [DATA_W-1:0] mplier_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] acc_next;
  logic [4:0]        cnt_reg;
  logic [DATA_W-1:0] data_reg;
  logic              zero_reg;
  logic [DATA_W-1:0] alu_result;

  // Single-cycle datapath; only the low five bits of data2 act as shift amount.
  always_comb begin
    alu_result = '0;
    case (ALUCtrl_i)
      OP_AND:  alu_result = data1_i & data2_i;
      OP_XOR:  alu_result = data1_i ^ data2_i;
      OP_SLL:  alu_result = data1_i << data2_i[4:0];
      OP_ADD:  alu_result = data1_i + data2_i;
      OP_SUB:  alu_result = data1_i - data2_i;
      OP_SRA:  alu_result = $signed(data1_i) >>> data2_i[4:0];
      default: alu_result = '0;  // MUL handled by the FSM, 111 is illegal -> 0
    endcase
  end

  // One shift-add step. Only the low product is kept, so the multiplicand
  // can be truncated to DATA_W bits as it shifts left.
  always_comb begin
    acc_next = acc_reg;
    if (mplier_reg[0]) begin
      acc_next = acc_reg + mcand_reg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg  <= ST_IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      data_reg   <= '0;
      zero_reg   <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (valid_i) begin
            if (ALUCtrl_i == OP_MUL) begin
              mcand_reg  <= data1_i;
              mplier_reg <= data2_i;
              acc_reg    <= '0;
              cnt_reg    <= '0;
              state_reg  <= ST_MUL_RUN;
            end else begin
              data_reg  <= alu_result;
              zero_reg  <= (alu_result == '0);
              state_reg <= ST_DONE;
            end
          end
        end
        ST_MUL_RUN: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 5'd1;
          // Step 31 is the last one: publish the product on this same edge.
          if (cnt_reg == 5'd31) begin
            data_reg  <= acc_next;
            zero_reg  <= (acc_next == '0);
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ready_o = (state_reg == ST_IDLE);
  assign valid_o = (state_reg == ST_DONE);
  assign data_o  = data_reg;
  assign zero_o  = zero_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic        zero_o;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.DATA_W(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .zero_o    (zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    check_eq("ready_before_send", {31'd0, ready_o}, 32'd1);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    @(negedge clk_i);
    valid_i   = 1'b0;
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check_eq("valid_after_consume", {31'd0, valid_o}, 32'd0);
    check_eq("ready_after_consume", {31'd0, ready_o}, 32'd1);
  endtask

  task automatic alu_test(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    send(op, a, b);
    check_eq({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    check_eq({tag, "_data"}, data_o, exp);
    check_eq({tag, "_zero"}, {31'd0, zero_o}, {31'd0, (exp == 32'd0)});
    $display("op=%b a=%h b=%h data=%h zero=%b (%s)", op, a, b, data_o, zero_o, tag);
    consume();
  endtask

  initial begin
    int cyc;
    int spurious;
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    ALUCtrl_i = 3'b000; data1_i = '0; data2_i = '0;

    repeat (3) @(negedge clk_i);
    check_eq("rst_ready", {31'd0, ready_o}, 32'd1);
    check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
    check_eq("rst_data", data_o, 32'd0);
    check_eq("rst_zero", {31'd0, zero_o}, 32'd1);
    rst_i = 1'b1;

    // First transfer on the first edge after release.
    alu_test("add_ovf", 3'b011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    alu_test("sub_zero", 3'b100, 32'd5, 32'd5, 32'd0);
    alu_test("sra", 3'b110, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000);
    alu_test("sll31", 3'b010, 32'h0000_0001, 32'd31, 32'h8000_0000);
    alu_test("and", 3'b000, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200);
    alu_test("xor", 3'b001, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    alu_test("sub_wrap", 3'b100, 32'd0, 32'd1, 32'hFFFF_FFFF);
    alu_test("illegal", 3'b111, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0);

    // MUL 0xFFFFFFFF^2: low product 1, valid exactly 32 edges after transfer.
    send(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc = 0;
    while (!valid_o && cyc < 40) begin
      check_eq("mul_ready_low", {31'd0, ready_o}, 32'd0);
      // Junk offers while busy; if sampled they would corrupt the result.
      valid_i   = cyc[0];
      ALUCtrl_i = 3'b011;
      data1_i   = 32'd0;
      data2_i   = 32'd0;
      @(negedge clk_i);
      cyc++;
    end
    valid_i = 1'b0;
    check_eq("mul_latency", cyc, 32);
    check_eq("mul_data", data_o, 32'h0000_0001);
    check_eq("mul_zero", {31'd0, zero_o}, 32'd0);
    $display("op=101 a=ffffffff b=ffffffff data=%h latency=%0d", data_o, cyc);
    consume();

    // Other multiply vector.
    send(3'b101, 32'd12345, 32'd678);
    cyc = 0;
    while (!valid_o && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
    end
    check_eq("mul2_latency", cyc, 32);
    check_eq("mul2_data", data_o, 32'd8369910);
    $display("op=101 a=12345 b=678 data=%0d", data_o);
    consume();

    // Stall: result held while ready_i is low, then back-to-back XOR.
    send(3'b011, 32'd3, 32'd4);
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_valid", {31'd0, valid_o}, 32'd1);
      check_eq("stall_data", data_o, 32'd7);
      @(negedge clk_i);
    end
    $display("op=011 a=3 b=4 data=%h held 10 cycles", data_o);
    consume();
    alu_test("b2b_xor", 3'b001, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F);

    // Reset mid-multiply: result must be lost.
    send(3'b101, 32'd7, 32'd6);
    repeat (14) @(negedge clk_i);
    check_eq("mulrst_pre_valid", {31'd0, valid_o}, 32'd0);
    #2 rst_i = 1'b0;
    #1;
    check_eq("mulrst_valid", {31'd0, valid_o}, 32'd0);
    check_eq("mulrst_data", data_o, 32'd0);
    check_eq("mulrst_zero", {31'd0, zero_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) spurious++;
      @(negedge clk_i);
    end
    check_eq("mulrst_no_result", spurious, 32'd0);
    $display("reset during MUL: spurious results=%0d", spurious);
    alu_test("add_after_rst", 3'b011, 32'd1, 32'd1, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
